// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and the
// request legality check used when a request is accepted.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int MEM_MASK_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } lsu_state_t;

    // Illegal funct3 for the access kind, or an address not aligned to its size.
    function automatic logic req_err(input logic store, input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
        logic err;
        case (funct3)
            F3_B:    err = 1'b0;
            F3_H:    err = addr_lo[0];
            F3_W:    err = (addr_lo != 2'b00);
            F3_BU:   err = store;
            F3_HU:   err = store | addr_lo[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store data replication and byte mask, plus load
// shift-down and sign/zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]            funct3,
    input  logic [1:0]            addr_lo,
    input  logic [XLEN-1:0]       st_data,
    input  logic [XLEN-1:0]       ld_word,
    output logic [XLEN-1:0]       st_data_rep,
    output logic [MEM_MASK_W-1:0] st_mask,
    output logic [XLEN-1:0]       ld_data
);

    logic [XLEN-1:0] ld_shift;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        st_data_rep = st_data;
        st_mask     = {4'b0000, 4'b1111};
        ld_shift    = ld_word >> {addr_lo, 3'b000};
        ld_data     = ld_shift;

        case (funct3[1:0])
            2'b00: begin
                st_data_rep = {4{st_data[7:0]}};
                st_mask     = {4'b0000, 4'b0001 << addr_lo};
            end
            2'b01: begin
                st_data_rep = {2{st_data[15:0]}};
                st_mask     = {4'b0000, 4'b0011 << addr_lo};
            end
            default: ;
        endcase

        case (funct3)
            F3_B:    ld_data = {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
            F3_BU:   ld_data = {{(XLEN-8){1'b0}}, ld_shift[7:0]};
            F3_H:    ld_data = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
            F3_HU:   ld_data = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control FSM: accepts a request, runs one memory cycle (skipped on
// error) and holds the response until the consumer takes it.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [XLEN-1:0]       resp_rdata,
    output logic                  resp_err,
    output logic                  mem_valid,
    output logic                  mem_wen,
    output logic [ADDR_W-1:0]     mem_raddr,
    output logic [ADDR_W-1:0]     mem_waddr,
    output logic [XLEN-1:0]       mem_wdata,
    output logic [MEM_MASK_W-1:0] mem_wmask,
    input  logic [XLEN-1:0]       mem_rdata
);

    lsu_state_t        state_q, state_d;
    logic              store_q, store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [XLEN-1:0]       st_data_rep;
    logic [MEM_MASK_W-1:0] st_mask;
    logic [XLEN-1:0]       ld_data;
    logic                  access;
    logic                  do_write;

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3      (funct3_q),
        .addr_lo     (addr_q[1:0]),
        .st_data     (wdata_q),
        .ld_word     (mem_rdata),
        .st_data_rep (st_data_rep),
        .st_mask     (st_mask),
        .ld_data     (ld_data)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            // NOTE: the datapath registers are reset as well because resp_rdata/resp_err are visible from reset.
            state_q  <= IDLE;
            store_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            store_q  <= store_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        store_d  = store_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    store_d  = req_store;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    err_d    = req_err(req_store, req_funct3, req_addr[1:0]);
                    state_d  = err_d ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (!store_q) begin
                    rdata_d = ld_data;
                end
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory strobes are decoded from the state register, so they vanish the cycle after ACCESS.
    assign access    = (state_q == ACCESS);
    assign do_write  = access & store_q;
    assign mem_valid = access;
    assign mem_wen   = do_write;
    assign mem_raddr = access ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_waddr = access ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wdata = do_write ? st_data_rep : '0;
    assign mem_wmask = do_write ? st_mask : '0;

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios then randomized
// transactions against a byte-level memory reference model.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_valid, mem_wen;
    logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;

    logic [7:0] dev_mem [64];
    logic [7:0] ref_mem [64];

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDR_W(32), .XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_valid  (mem_valid),
        .mem_wen    (mem_wen),
        .mem_raddr  (mem_raddr),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_rdata  (mem_rdata)
    );

    // Device memory: 64-byte window, combinational read, masked write on the clock.
    always_comb begin
        mem_rdata = {dev_mem[{mem_raddr[5:2], 2'd3}], dev_mem[{mem_raddr[5:2], 2'd2}],
                     dev_mem[{mem_raddr[5:2], 2'd1}], dev_mem[{mem_raddr[5:2], 2'd0}]};
    end

    always @(posedge clk) begin
        if (mem_valid && mem_wen) begin
            wr_count <= wr_count + 1;
            for (int i = 0; i < 4; i++) begin
                if (mem_wmask[i]) dev_mem[int'(mem_waddr[5:0]) + i] <= mem_wdata[8*i +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic exp_err(input logic st, input logic [2:0] f3, input logic [31:0] addr);
        logic legal;
        legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 1'b1;
        return (int'(addr[5:0]) % size_of(f3)) != 0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr);
        int sz = size_of(f3);
        logic [31:0] v = 0;
        for (int i = 0; i < sz; i++) v |= 32'(ref_mem[int'(addr[5:0]) + i]) << (8*i);
        if (!f3[2] && sz < 4 && v[8*sz-1]) v |= ~((32'd1 << (8*sz)) - 32'd1);
        return v;
    endfunction

    function automatic logic [31:0] exp_mask(input logic [2:0] f3, input logic [31:0] addr);
        int sz = size_of(f3);
        if (sz == 4) return 32'h0F;
        return ((32'd1 << sz) - 32'd1) << (addr % 4);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int sz = size_of(f3);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[8*i +: 8] = wd[8*(i % sz) +: 8];
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        for (int i = 0; i < size_of(f3); i++) ref_mem[int'(addr[5:0]) + i] = wd[8*i +: 8];
    endtask

    // ---------------- transaction driver ----------------
    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int hold);
        logic        e;
        logic [31:0] er;
        int          w0;
        e  = exp_err(st, f3, addr);
        er = (st || e) ? 32'd0 : exp_load(f3, addr);
        check("req_ready_idle", req_ready, 1);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        resp_ready = 1'b0;
        w0 = wr_count;
        @(negedge clk);
        // Garbage request held while busy must be ignored.
        req_store  = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        if (!e) begin
            check("acc_mem_valid", mem_valid, 1);
            check("acc_mem_wen", mem_wen, st);
            check("acc_raddr", mem_raddr, {addr[31:2], 2'b00});
            check("acc_waddr", mem_waddr, {addr[31:2], 2'b00});
            check("acc_resp_valid", resp_valid, 0);
            check("acc_req_ready", req_ready, 0);
            if (st) begin
                check("acc_wmask", 32'(mem_wmask), exp_mask(f3, addr));
                check("acc_wdata", mem_wdata, exp_wdata(f3, wd));
                ref_store(f3, addr, wd);
            end
            @(negedge clk);
        end else begin
            check("err_no_mem", mem_valid, 0);
        end
        for (int k = 0; k <= hold; k++) begin
            check("resp_valid", resp_valid, 1);
            check("resp_rdata", resp_rdata, er);
            check("resp_err", resp_err, e);
            check("resp_req_ready", req_ready, 0);
            check("resp_no_mem", mem_valid, 0);
            if (k < hold) @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        check("post_resp_valid", resp_valid, 0);
        check("post_req_ready", req_ready, 1);
        check("write_count", 32'(wr_count - w0), (st && !e) ? 32'd1 : 32'd0);
    endtask

    task automatic reset_during_store(input logic [31:0] addr, input logic [31:0] wd);
        int w0;
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = F3_W;
        req_addr   = addr;
        req_wdata  = wd;
        w0 = wr_count;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_acc_mem_valid", mem_valid, 1);
        rst = 1'b1;
        ref_store(F3_W, addr, wd);
        @(negedge clk);
        rst = 1'b0;
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_rdata", resp_rdata, 0);
        for (int k = 0; k < 4; k++) begin
            check("rst_resp_valid", resp_valid, 0);
            check("rst_mem_valid", mem_valid, 0);
            @(negedge clk);
        end
        check("rst_write_once", 32'(wr_count - w0), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            dev_mem[i] = 8'($urandom);
            ref_mem[i] = dev_mem[i];
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_err", resp_err, 0);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_mem_wen", mem_wen, 0);
        check("rst_mem_raddr", mem_raddr, 0);
        check("rst_mem_waddr", mem_waddr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_wmask", 32'(mem_wmask), 0);
        @(negedge clk);

        txn(1'b1, F3_W,  32'h8000_0004, 32'hDEAD_BEEF, 0);
        txn(1'b1, F3_B,  32'h8000_0003, 32'h0000_00A5, 0);
        txn(1'b1, F3_W,  32'h8000_0010, 32'h8000_F0FF, 0);
        txn(1'b0, F3_B,  32'h8000_0011, 32'h0, 0);
        txn(1'b0, F3_BU, 32'h8000_0011, 32'h0, 0);
        txn(1'b0, F3_H,  32'h8000_0012, 32'h0, 0);
        txn(1'b0, F3_W,  32'h8000_0010, 32'h0, 0);
        txn(1'b0, F3_H,  32'h8000_0001, 32'h0, 0);
        txn(1'b0, F3_W,  32'h8000_0002, 32'h0, 0);
        txn(1'b1, 3'b100, 32'h8000_0000, 32'h1234_5678, 0);
        txn(1'b1, F3_H,  32'h8000_0016, 32'h0000_BEEF, 5);
        txn(1'b0, F3_HU, 32'h8000_0016, 32'h0, 5);

        reset_during_store(32'h8000_0020, 32'hCAFE_F00D);
        txn(1'b0, F3_W,  32'h8000_0020, 32'h0, 0);

        for (int n = 0; n < 300; n++) begin
            a = 32'h8000_0000 | 32'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            txn(1'($urandom), 3'($urandom), a, $urandom, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store control unit between the pipeline's MEM stage and the combinational data-memory port. Accepts one load or store request per transaction through a valid/ready handshake and checks alignment. It builds the word-aligned address, byte-lane write mask and replicated store data, drives a single-cycle memory access, then returns the sign- or zero-extended load result (or a misalignment/illegal error) through a second valid/ready handshake.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `XLEN`, 32, data width (fixed 32; the parameter exists for checking only).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; one clock, synchronous active-high reset.
- `req_valid`  in  1  MEM stage presents a request.
- `req_ready`  out  1  high only in IDLE.
- `req_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I load/store funct3.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store source (rs2).
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts the result.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned access or illegal funct3.
- `mem_valid`  out  1  memory access strobe.
- `mem_wen`  out  1  write enable.
- `mem_raddr`  out  32  word-aligned read address.
- `mem_waddr`  out  32  word-aligned write address.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_wmask`  out  8  byte enables; bits [7:4] are always 0.
- `mem_rdata`  in  32  combinational read data.

## Operation
- FSM has three states: IDLE, ACCESS and RESP.
- **IDLE:**
  - On `req_valid && req_ready`, register the store flag, funct3, address and wdata.
  - Compute `err` from the request. It is set for illegal funct3: loads other than 000/001/010/100/101, stores other than 000/001/010.
  - It is also set for misalignment: a halfword with `addr[0]`=1, or a word with `addr[1:0]`≠0.
  - If `err`, go to RESP; otherwise go to ACCESS.
- **ACCESS:** exactly one cycle.
  - Drive `mem_valid`=1 and `mem_raddr`=`mem_waddr`={addr[31:2],2'b00}.
  - Stores: `mem_wen`=1.
    - Byte: wmask = 0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
    - Half: wmask = 0011<<addr[1:0], wdata = {2{wdata[15:0]}}.
    - Word: wmask = 1111, wdata unchanged.
  - Loads:
    - Sample `mem_rdata` at the end of the cycle and shift right by 8·addr[1:0].
    - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
    - Register the result into `resp_rdata`.
  - Next state is RESP.
- **RESP:** `resp_valid`=1 with `resp_rdata`/`resp_err` held stable. On `resp_ready` go to IDLE.
- All `mem_*` outputs come from registers or the state decode and are 0 outside ACCESS. No write may reach memory in any other state.
- Reset in any state: go to IDLE next cycle and abort any in-flight access. A store in ACCESS during the reset cycle still sees its strobe that cycle, but must not repeat.

## Timing
- Reset values:
  - `req_ready`=1 after reset deasserts (IDLE).
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
  - All `mem_*` = 0.
- Latency:
  - Accept at cycle N, `mem_valid` in N+1, `resp_valid` in N+2.
  - Error path: `resp_valid` in N+1 with no memory cycle.
- Throughput: at most one transaction per 3 cycles (2 on the error path). A new request may be accepted in the cycle after the `resp_valid && resp_ready` handshake, not in the same cycle.
- Backpressure: `resp_valid` is held until `resp_ready`; `resp_*` must not change while held.
- Request inputs are ignored when `req_ready`=0.

## Structure
- Shared package `lsu_pkg` holds:
  - funct3 constants `F3_B`=000, `F3_H`=001, `F3_W`=010, `F3_BU`=100, `F3_HU`=101;
  - the state enum `lsu_state_t` {IDLE, ACCESS, RESP};
  - the `MEM_MASK_W`=8 constant.
- One combinational sub-module, `lsu_align`, does the store lane replication and mask generation plus the load shift and extension. `lsu_ctrl` holds the FSM and registers.

## Test plan
- SW addr 0x80000004 data 0xDEADBEEF → one cycle with `mem_valid`=1, `mem_wen`=1, `mem_waddr`=0x80000004, `mem_wmask`=0x0F; `resp_err`=0.
- SB addr 0x80000003 data 0x000000A5 → `mem_wdata`=0xA5A5A5A5, `mem_wmask`=0x08, `mem_waddr`=0x80000000.
- Memory word 0x8000F0FF at 0x80000010: LB addr+1 → 0xFFFFFFF0; LBU addr+1 → 0x000000F0; LH addr+2 → 0xFFFF8000; LW → 0x8000F0FF.
- LH addr 0x80000001 and LW addr 0x80000002 → `resp_valid` one cycle after accept, `resp_err`=1, `resp_rdata`=0, `mem_valid` never asserted. Store funct3 100 → `resp_err`=1.
- Hold `resp_ready`=0 for 5 cycles → `resp_valid` and data stable, `req_ready`=0, no further memory strobe. Release → IDLE and the next request is accepted.
- Assert `rst` during ACCESS of a store → IDLE next cycle, `resp_valid` stays 0, exactly one write strobe total.
